// File: rtl/alu_op_sequencer.sv
// Issue/capture stage wrapped around a combinational 4-bit ALU.
// Operands are registered onto the ALU, and the result is captured one cycle later and offered downstream.
module alu_op_sequencer #(
    parameter int DW    = 4,
    parameter int SW    = 3,
    parameter int OW    = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic [SW-1:0]    in_sel,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [SW-1:0]    alu_sel,
    input  logic [OW-1:0]    alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OW-1:0]    res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    // state | meaning
    // IDLE  | nothing in flight, ready for an operation
    // EXEC  | operands on the ALU, result settling this cycle
    // DONE  | result captured and offered downstream
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    logic   accept;
    logic   div_zero;

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & res_ready);
    assign accept   = in_valid & in_ready;
    // Opcodes 011 (divide) and 100 (modulo) have no defined ALU result for b == 0
    assign div_zero = ((alu_sel == SW'(3)) | (alu_sel == SW'(4))) & (alu_b == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a   <= in_a;
                        alu_b   <= in_b;
                        alu_sel <= in_sel;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_err   <= div_zero;
                    res_data  <= div_zero ? {OW{1'b1}} : alu_out;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        // Back-to-back: a new op can be taken in the same cycle as the handoff
                        if (accept) begin
                            alu_a   <= in_a;
                            alu_b   <= in_b;
                            alu_sel <= in_sel;
                            state   <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
